// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: assembles serial samples into 8-sample frames in a ping-pong
// double buffer and presents each complete frame in parallel to the 8-point FFT.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   s_data/s_valid/s_sof/s_ready  serial sample input with start-of-frame marker
//   a0..a7              frame samples 0..7 (a0 = first sample) to FFT inputs A0..A7
//   m_valid/m_ready     frame output handshake
//   drop_pulse          one-cycle pulse when a partial frame is discarded by resync
//   drop_cnt            saturating count of discarded partial frames
//
// Build option: define FFT8_IN_PRESCALE_EN to store every sample arithmetically
// shifted right by 3, pre-compensating the FFT's 8x worst-case growth.
module fft8_frame_loader #(
   parameter int DW    = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    s_data,
   input  logic             s_valid,
   input  logic             s_sof,
   output logic             s_ready,
   output logic [DW-1:0]    a0,
   output logic [DW-1:0]    a1,
   output logic [DW-1:0]    a2,
   output logic [DW-1:0]    a3,
   output logic [DW-1:0]    a4,
   output logic [DW-1:0]    a5,
   output logic [DW-1:0]    a6,
   output logic [DW-1:0]    a7,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             drop_pulse,
   output logic [CNT_W-1:0] drop_cnt
);
   logic [DW-1:0] bank [2][8];
   logic [1:0]    full;
   logic          wr_bank;
   logic          rd_bank;
   logic [2:0]    wr_idx;
   logic          accept;
   logic          resync;
   logic          done;
   logic          rel;
   logic [1:0]    full_set;
   logic [1:0]    full_clr;
   logic [DW-1:0] sample;

   // both handshakes look only at registered flags, so m_ready never reaches s_ready
   assign s_ready  = !full[wr_bank];
   assign m_valid  = full[rd_bank];
   assign accept   = s_valid && s_ready;
   assign rel      = m_valid && m_ready;
   // a start marker in the middle of a frame restarts the frame at index 0
   assign resync   = accept && s_sof && (wr_idx != 3'd0);
   assign done     = accept && !resync && (wr_idx == 3'd7);
   // completion only targets a clear bank and release only a full one, so set and
   // clear never collide on the same flag
   assign full_set = done ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr = rel ? (2'b01 << rd_bank) : 2'b00;

`ifdef FFT8_IN_PRESCALE_EN
   assign sample = $signed(s_data) >>> 3;
`else
   assign sample = s_data;
`endif

   // outputs come straight from bank registers, never from s_data
   assign a0 = bank[rd_bank][0];
   assign a1 = bank[rd_bank][1];
   assign a2 = bank[rd_bank][2];
   assign a3 = bank[rd_bank][3];
   assign a4 = bank[rd_bank][4];
   assign a5 = bank[rd_bank][5];
   assign a6 = bank[rd_bank][6];
   assign a7 = bank[rd_bank][7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++)
               bank[b][i] <= '0;
         full       <= 2'b00;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_idx     <= 3'd0;
         drop_pulse <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (accept) begin
            bank[wr_bank][resync ? 3'd0 : wr_idx] <= sample;
            // index 7 + 1 wraps to 0, starting the next frame
            wr_idx <= resync ? 3'd1 : wr_idx + 3'd1;
         end
         if (done) wr_bank <= !wr_bank;
         if (rel) rd_bank <= !rd_bank;
         full       <= (full & ~full_clr) | full_set;
         drop_pulse <= resync;
         if (resync && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fft8_frame_loader.sv
// tb_fft8_frame_loader: self-checking bench for fft8_frame_loader using a frame-queue
// reference model checked every cycle plus directed literal expectations.
module tb_fft8_frame_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_sof = 1'b0;
   logic         s_ready;
   logic [31:0]  a0, a1, a2, a3, a4, a5, a6, a7;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         drop_pulse;
   logic [7:0]   drop_cnt;
   logic [255:0] acat;

   int n_chk = 0;
   int n_fail = 0;
   int tries = 0;
   bit chk_en = 0;

   logic [255:0] fq[$];
   logic [255:0] part = '0;
   int           idx = 0;
   int           mcnt = 0;
   bit           mdrop = 0;
   bit           m_rdy, m_vld;

   fft8_frame_loader #(.DW(32), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
      .s_ready(s_ready), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5),
      .a6(a6), .a7(a7), .m_valid(m_valid), .m_ready(m_ready),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   assign acat = {a7, a6, a5, a4, a3, a2, a1, a0};

   always #5 clk = ~clk;

   function automatic logic [31:0] st(input logic [31:0] v);
`ifdef FFT8_IN_PRESCALE_EN
      return $signed(v) >>> 3;
`else
      return v;
`endif
   endfunction

   function automatic logic [255:0] frm(input logic [31:0] b);
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = st(b + i);
      return f;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // model: pending complete frames in a queue (at most two), plus the frame being filled
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         fq.delete();
         idx = 0;
         mcnt = 0;
         mdrop = 0;
      end else begin
         m_rdy = fq.size() < 2;
         m_vld = fq.size() > 0;
         mdrop = 0;
         if (m_vld && m_ready) void'(fq.pop_front());
         if (s_valid && m_rdy) begin
            if (s_sof && idx != 0) begin
               part[31:0] = st(s_data);
               idx = 1;
               mdrop = 1;
               if (mcnt < 255) mcnt++;
            end else begin
               part[idx*32 +: 32] = st(s_data);
               idx++;
               if (idx == 8) begin
                  fq.push_back(part);
                  idx = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_s_ready", s_ready, fq.size() < 2);
         chk("cyc_m_valid", m_valid, fq.size() > 0);
         chk("cyc_drop_pulse", drop_pulse, mdrop);
         chk("cyc_drop_cnt", drop_cnt, mcnt);
         if (fq.size() > 0) chk("cyc_frame", acat, fq[0]);
      end
   end

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [31:0] v, input logic sof);
      bit ok = 0;
      s_data = v;
      s_sof = sof;
      s_valid = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         ok = s_ready;
         tries++;
         @(posedge clk);
         @(negedge clk);
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: got no accept expected accept of %h", v);
      end
      s_valid = 1'b0;
      s_sof = 1'b0;
   endtask

   initial begin
      logic [255:0] e;
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk_en = 1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_a", acat, 0);
      chk("rst_drop_cnt", drop_cnt, 0);

      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(1 + i, i == 0);
      chk("t1_m_valid", m_valid, 1);
      chk("t1_frame", acat, frm(1));
      chk("t1_drop_cnt", drop_cnt, 0);
      @(negedge clk);
      chk("t1_released", m_valid, 0);

      m_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(101 + i, i % 8 == 0);
      chk("t2_s_ready_full", s_ready, 0);
      chk("t2_m_valid", m_valid, 1);
      chk("t2_frame1", acat, frm(101));
      repeat (3) @(negedge clk);
      chk("t2_hold", acat, frm(101));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("t2_s_ready_back", s_ready, 1);
      chk("t2_frame2", acat, frm(109));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("t2_empty", m_valid, 0);

      m_ready = 1'b1;
      tries = 0;
      for (int i = 0; i < 64; i++) send(1000 + i, i % 8 == 0);
      chk("t3_no_stall", tries, 64);
      repeat (2) @(negedge clk);
      chk("t3_drained", m_valid, 0);

      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(2001 + i, i == 0);
      send(32'hA5, 1'b1);
      chk("t4_drop_pulse", drop_pulse, 1);
      chk("t4_drop_cnt", drop_cnt, 1);
      send(2006, 1'b0);
      chk("t4_drop_pulse_end", drop_pulse, 0);
      for (int i = 1; i < 7; i++) send(2006 + i, 1'b0);
      e = frm(2005);
      e[31:0] = st(32'hA5);
      chk("t4_m_valid", m_valid, 1);
      chk("t4_frame", acat, e);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;

      for (int i = 0; i < 8; i++) send(3001 + i, i == 0);
      for (int i = 0; i < 3; i++) send(3009 + i, i == 0);
      #2 rst = 1'b1;
      #1;
      chk("t5_m_valid", m_valid, 0);
      chk("t5_s_ready", s_ready, 1);
      chk("t5_a", acat, 0);
      chk("t5_drop_cnt", drop_cnt, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) send(4001 + i, i == 0);
      chk("t5_frame", acat, frm(4001));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;

      for (int k = 0; k < 260; k++) begin
         send(5000, 1'b0);
         send(5001, 1'b1);
      end
      chk("t6_drop_sat", drop_cnt, 255);
      chk("t6_no_frame", m_valid, 0);

`ifdef FFT8_IN_PRESCALE_EN
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      send(32'hFFFFFFF0, 1'b1);
      send(32'd40, 1'b0);
      for (int i = 0; i < 6; i++) send(0, 1'b0);
      chk("pre_neg", acat[31:0], 32'hFFFFFFFE);
      chk("pre_pos", acat[63:32], 32'h00000005);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
